parking_request_queue: RTL and testbench

PARKING_REQUEST_QUEUE -- requirements
Module: parking_request_queue

---
 rtl/parking_request_queue.sv | 162 ++++++++++++++++
 tb/tb_parking_request_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_request_queue.sv
// Gate-side request queue for the parking-lot controller: a 4-deep FIFO of
// {plate, dir} plus an issue FSM that hands one entry at a time downstream.
module parking_request_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_plate,
  input  logic        req_dir,
  input  logic        leakage,
  input  logic        ctrl_busy,
  output logic [15:0] license_plate,
  output logic        in_mode,
  output logic        out_mode,
  output logic        req_ready,
  output logic [2:0]  count,
  output logic        full,
  output logic        empty,
  output logic        drop_err
);

  localparam int DEPTH = 4;
  localparam logic [2:0] COUNT_FULL = 3'd4;
  localparam logic [1:0] ACK_LAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ack_cnt_reg, ack_cnt_next;

  logic [15:0] fifo_plate [DEPTH];
  logic        fifo_dir   [DEPTH];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  count_reg, count_next;
  logic        full_reg, empty_reg, drop_reg;

  logic [15:0] plate_reg;
  logic        in_mode_reg, out_mode_reg;

  logic [3:0]  nibble_ok;
  logic        plate_ok;
  logic        push, pop, drop, issue_next;

  // A plate is four BCD digits and may not be all zeros.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      assign nibble_ok[gi] = (req_plate[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign plate_ok = (&nibble_ok) && (req_plate != 16'h0000);
  assign push     = req_valid && !full_reg && plate_ok;
  assign drop     = req_valid && !push;
  assign pop      = (state_reg == ISSUE);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset: the pointers and count define which slots are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_plate[wr_ptr_reg] <= req_plate;
      fifo_dir[wr_ptr_reg]   <= req_dir;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      drop_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_FULL);
      empty_reg <= (count_next == 3'd0);
      drop_reg  <= drop;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ack_cnt_next = ack_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !leakage && !ctrl_busy) state_next = ISSUE;
      end
      ISSUE: begin
        state_next   = WAIT_ACK;
        ack_cnt_next = 2'd0;
      end
      WAIT_ACK: begin
        // Controller never went busy: treat as rejected/instant after 3 idle cycles.
        if (ctrl_busy) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt_reg == ACK_LAST) begin
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt_reg + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!ctrl_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      ack_cnt_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      ack_cnt_reg <= ack_cnt_next;
    end
  end

  // Command outputs are loaded on the edge entering ISSUE so they line up with it.
  assign issue_next = (state_reg == IDLE) && (state_next == ISSUE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      plate_reg    <= 16'h0000;
      in_mode_reg  <= 1'b0;
      out_mode_reg <= 1'b0;
    end else if (issue_next) begin
      plate_reg    <= fifo_plate[rd_ptr_reg];
      in_mode_reg  <= !fifo_dir[rd_ptr_reg];
      out_mode_reg <= fifo_dir[rd_ptr_reg];
    end else begin
      plate_reg    <= 16'h0000;
      in_mode_reg  <= 1'b0;
      out_mode_reg <= 1'b0;
    end
  end

  assign license_plate = plate_reg;
  assign in_mode       = in_mode_reg;
  assign out_mode      = out_mode_reg;
  assign count         = count_reg;
  assign full          = full_reg;
  assign empty         = empty_reg;
  assign req_ready     = !full_reg;
  assign drop_err      = drop_reg;

endmodule

// File: tb/tb_parking_request_queue.sv
// Directed bench for parking_request_queue: a vector table for the basic
// queue/issue behaviour plus sequences for leakage, reset and pointer wrap.
module tb_parking_request_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_plate;
  logic        req_dir;
  logic        leakage;
  logic        ctrl_busy;
  logic [15:0] license_plate;
  logic        in_mode, out_mode, req_ready, full, empty, drop_err;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  parking_request_queue dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_plate(req_plate),
    .req_dir(req_dir), .leakage(leakage), .ctrl_busy(ctrl_busy),
    .license_plate(license_plate), .in_mode(in_mode), .out_mode(out_mode),
    .req_ready(req_ready), .count(count), .full(full), .empty(empty),
    .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rv;
    logic [15:0] plate;
    logic        dir;
    logic        leak;
    logic        busy;
    logic [15:0] lp;
    logic        im;
    logic        om;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;
    logic        drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rv, input logic [15:0] plate, input logic dir,
                             input logic leak, input logic busy, input logic [15:0] lp,
                             input logic im, input logic om, input logic [2:0] cnt,
                             input logic f, input logic e, input logic d);
    vec_t t;
    t = '{rv: rv, plate: plate, dir: dir, leak: leak, busy: busy, lp: lp, im: im,
          om: om, cnt: cnt, full: f, empty: e, drop: d};
    return t;
  endfunction

  function automatic logic [15:0] wrap_plate(input int i);
    logic [3:0] d;
    d = i[3:0];
    return {d, 4'd9 - d, d, 4'd1};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic rv, input logic [15:0] plate, input logic dir,
                       input logic leak, input logic busy);
    req_valid = rv;
    req_plate = plate;
    req_dir   = dir;
    leakage   = leak;
    ctrl_busy = busy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [24:0] act_o, exp_o;
    logic [16:0] exp_q[$];
    logic [16:0] got_e, exp_e;
    int cmds, idx, last_cyc, drops;

    // ---- vector table: {inputs} -> {lp, im, om, cnt, full, empty, drop} after the edge
    vecs.push_back(v(1, 16'h9423, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h9423, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 16'h12A4, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 16'h1111, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 16'h2222, 0, 0, 1, 16'h0000, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v(1, 16'h3333, 0, 0, 1, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 16'h4444, 0, 0, 1, 16'h0000, 0, 0, 4, 1, 0, 0));
    vecs.push_back(v(1, 16'h5555, 0, 0, 1, 16'h0000, 0, 0, 4, 1, 0, 1));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h1111, 1, 0, 4, 1, 0, 0));
    // push while full in the pop cycle is still rejected
    vecs.push_back(v(1, 16'h6666, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h2222, 1, 0, 3, 0, 0, 0));
    // simultaneous push and pop keeps count
    vecs.push_back(v(1, 16'h7777, 1, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h3333, 1, 0, 3, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h4444, 1, 0, 2, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h7777, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0));

    // ---- reset state
    reset = 1'b0;
    drive(0, 16'h0000, 0, 0, 0);
    tick();
    tick();
    check("reset_state",
          {7'd0, license_plate, in_mode, out_mode, count, full, empty, drop_err, req_ready},
          {7'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rv, vecs[i].plate, vecs[i].dir, vecs[i].leak, vecs[i].busy);
      tick();
      act_o = {license_plate, in_mode, out_mode, count, full, empty, drop_err, req_ready};
      exp_o = {vecs[i].lp, vecs[i].im, vecs[i].om, vecs[i].cnt, vecs[i].full,
               vecs[i].empty, vecs[i].drop, !vecs[i].full};
      check($sformatf("vec%0d", i), {7'd0, act_o}, {7'd0, exp_o});
    end

    // ---- leakage holds off issue; handshake through WAIT_DONE
    drive(1, 16'h8754, 1, 1, 0);
    tick();
    cmds = 0;
    drive(0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (in_mode || out_mode) cmds++;
    end
    check("leak_no_cmd", cmds, 0);
    check("leak_count_held", {29'd0, count}, 32'd1);
    leakage = 1'b0;
    tick();
    check("leak_release_cmd", {14'd0, license_plate, in_mode, out_mode},
          {14'd0, 16'h8754, 1'b0, 1'b1});
    tick();
    cmds = 0;
    drive(1, 16'h1357, 0, 0, 1);
    tick();
    if (in_mode || out_mode) cmds++;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (in_mode || out_mode) cmds++;
    end
    check("busy_no_cmd", cmds, 0);
    check("busy_count", {29'd0, count}, 32'd1);
    ctrl_busy = 1'b0;
    tick();
    check("busy_fall_gap", {30'd0, in_mode, out_mode}, 32'd0);
    tick();
    check("next_cmd", {14'd0, license_plate, in_mode, out_mode},
          {14'd0, 16'h1357, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) tick();

    // ---- reset in WAIT_DONE with two entries queued
    drive(1, 16'h1001, 0, 0, 0);
    tick();
    drive(1, 16'h2002, 1, 0, 0);
    tick();
    drive(1, 16'h3003, 0, 0, 1);
    tick();
    drive(0, 16'h0000, 0, 0, 1);
    tick();
    tick();
    check("pre_reset_count", {29'd0, count}, 32'd2);
    reset = 1'b0;
    tick();
    check("mid_reset_state",
          {7'd0, license_plate, in_mode, out_mode, count, full, empty, drop_err, req_ready},
          {7'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    reset = 1'b1;
    tick();
    tick();
    ctrl_busy = 1'b0;
    cmds = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (in_mode || out_mode) cmds++;
    end
    check("post_reset_no_cmd", cmds, 0);
    check("post_reset_count", {29'd0, count}, 32'd0);

    // ---- ten entries through the pointer wrap, no controller response
    cmds = 0;
    idx = 0;
    last_cyc = 0;
    drops = 0;
    for (int cyc = 0; cyc < 200 && cmds < 10; cyc++) begin
      if (idx < 10 && req_ready) begin
        drive(1, wrap_plate(idx), idx[0], 0, 0);
        exp_q.push_back({idx[0], wrap_plate(idx)});
        idx++;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (drop_err) drops++;
      if (in_mode || out_mode) begin
        cmds++;
        got_e = {out_mode, license_plate};
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        check($sformatf("wrap_cmd%0d", cmds), {15'd0, got_e}, {15'd0, exp_e});
        check($sformatf("wrap_mode%0d", cmds), {31'd0, in_mode ^ out_mode}, 32'd1);
        if (cmds > 1) check($sformatf("wrap_gap%0d", cmds), cyc - last_cyc, 5);
        last_cyc = cyc;
      end
    end
    req_valid = 1'b0;
    check("wrap_cmd_total", cmds, 10);
    check("wrap_drops", drops, 0);
    for (int i = 0; i < 5; i++) tick();
    check("wrap_drained", {30'd0, count == 3'd0, empty}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
